db4_synlatti: RTL
=================

DB4_SYNLATTI -- requirements
Module: db4_synlatti

Interface
REQ-001 SHALL have parameter IW, default 9, input sample width (g_in, h_in).
REQ-002 SHALL have parameter DW, default 20, internal signed datapath width.
REQ-003 SHALL have parameter OW, default 9, output sample width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  a g/h coefficient pair is presented.
REQ-007 SHALL have port in_ready  output  1  block can accept a pair this cycle; equals (phase == 0), combinational.
REQ-008 SHALL have port g_in  input  IW  signed lowpass coefficient, half-rate.
REQ-009 SHALL have port h_in  input  IW  signed highpass coefficient, half-rate.
REQ-010 SHALL have port out_valid  output  1  x_out holds a new reconstructed sample.
REQ-011 SHALL have port x_out  output  OW  signed reconstructed sample, full rate.
REQ-012 SHALL have port phase  output  1  0 = even slot, 1 = odd slot (half-rate clock indicator).

Function
REQ-013 SHALL accept a pair when in_valid && in_ready; otherwise in phase 0 it holds all state and drives out_valid=0.
REQ-014 SHALL prescale on acceptance: G = g_in <<< 8, H = h_in <<< 8, both DW bits.
REQ-015 SHALL define c1(v) = (v>>>2)+(v>>>6)+(v>>>8) and a0(v) = (v<<<1)-(v>>>2)-(v>>>6)-(v>>>8); all shifts arithmetic (floor).
REQ-016 SHALL compute inverse stage 1 combinationally: u = G + c1(H), l = H - c1(G).
REQ-017 SHALL hold the upper branch in register u_d, loaded with u on every acceptance.
REQ-018 SHALL compute inverse stage 0 from the pre-update u_d and the current l: xl = (a0(u_d) + l) >>> 2, xu = (u_d - a0(l)) >>> 2.
REQ-019 SHALL register on acceptance: x_out <= xl >>> 8 (older sample), xu_r <= xu, out_valid <= 1, phase <= 1.
REQ-020 SHALL in phase 1 register x_out <= xu_r >>> 8, out_valid <= 1, phase <= 0, ignoring in_valid.
REQ-021 SHALL output samples with 1-cycle latency from acceptance, order xl then xu; sustained throughput one pair per 2 cycles.
REQ-022 SHALL truncate to OW bits with no saturation; |x_out| <= 223 for all legal inputs, so truncation is lossless.
REQ-023 SHALL hold x_out at its last value whenever out_valid=0.

Reset
REQ-024 SHALL on reset set phase=0, out_valid=0, x_out=0, u_d=0, xu_r=0; in_ready is 1 in the cycle after reset deasserts.
REQ-025 SHALL give reset priority over acceptance; a pair presented during reset is dropped and a pending odd sample is discarded.

Structure
REQ-026 SHALL place IW/DW/OW defaults and the c1/a0 shift constants (2, 6, 8, scale 8) in shared package db4_pkg, also used by the analysis filter.
REQ-027 SHALL implement the shift-add multipliers in one sub-module db4_csd_mul (select c1 or a0); four instances.

Verification
REQ-028 SHALL check reset: reset high 3 cycles -> x_out=0, out_valid=0, phase=0, in_ready=1 after release.
REQ-029 SHALL check impulse: pair (100,0), then (0,0) back-to-back -> x_out = -7, 11, 43, 25 on consecutive cycles, out_valid high throughout.
REQ-030 SHALL check steady full-scale: (255,255) repeated -> from the second pair on, x_out = 186, 0 per pair; (-256,-256) repeated -> -188, -1.
REQ-031 SHALL check stall: in_valid low 5 cycles in phase 0 -> in_ready=1, out_valid=0, x_out and u_d unchanged; the next pair resumes the sequence.
REQ-032 SHALL check phase-1 rule: in_valid held high continuously -> exactly one acceptance per 2 cycles, in_ready=0 in every phase-1 cycle.
REQ-033 SHALL check reset mid-operation: reset asserted in phase 1 after accepting (100,0) -> the value 11 is never output; after release, pair (0,0) -> 0, 0 (u_d cleared).

Source files
------------

// File: rtl/db4_pkg.sv
// Shared constants for the DB4 lattice analysis/synthesis filters.
// c1(v) = v/4 + v/64 + v/256 ; a0(v) = 2v - c1(v) ; samples are prescaled by 2^8.
package db4_pkg;

  localparam int IW_DEF   = 9;
  localparam int DW_DEF   = 20;
  localparam int OW_DEF   = 9;

  localparam int C1_SH_A  = 2;
  localparam int C1_SH_B  = 6;
  localparam int C1_SH_C  = 8;
  localparam int SCALE_SH = 8;

  typedef enum logic {
    MUL_C1 = 1'b0,
    MUL_A0 = 1'b1
  } mul_sel_e;

endpackage

// File: rtl/db4_csd_mul.sv
// Shift-add constant multiplier for the lattice coefficients c1 or a0.
module db4_csd_mul
  import db4_pkg::*;
#(
  parameter int       DW  = DW_DEF,
  parameter mul_sel_e SEL = MUL_C1
) (
  input  logic signed [DW-1:0] v,
  output logic signed [DW-1:0] y
);

  logic signed [DW-1:0] tail;

  // a0 shares the c1 partial-product sum: a0(v) = 2v - c1(v)
  always_comb begin
    tail = (v >>> C1_SH_A) + (v >>> C1_SH_B) + (v >>> C1_SH_C);
    if (SEL == MUL_C1) y = tail;
    else               y = (v <<< 1) - tail;
  end

endmodule

// File: rtl/db4_synlatti.sv
// DB4 inverse lattice (synthesis) filter: one g/h pair in, two samples out.
//   state   | meaning
//   PH_EVEN | ready for a pair; emits xl on acceptance
//   PH_ODD  | emits the held xu sample, input ignored
module db4_synlatti
  import db4_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] g_in,
  input  logic signed [IW-1:0] h_in,
  output logic                 out_valid,
  output logic signed [OW-1:0] x_out,
  output logic                 phase
);

  localparam logic [0:0] PH_EVEN = 1'b0;
  localparam logic [0:0] PH_ODD  = 1'b1;

  logic signed [DW-1:0] g_s, h_s;
  logic signed [DW-1:0] c1_g, c1_h, a0_ud, a0_l;
  logic signed [DW-1:0] u, l, xl, xu;
  logic signed [DW-1:0] u_d, xu_r;

  assign g_s = DW'(g_in) <<< SCALE_SH;
  assign h_s = DW'(h_in) <<< SCALE_SH;

  db4_csd_mul #(.DW(DW), .SEL(MUL_C1)) u_c1_h  (.v(h_s), .y(c1_h));
  db4_csd_mul #(.DW(DW), .SEL(MUL_C1)) u_c1_g  (.v(g_s), .y(c1_g));
  db4_csd_mul #(.DW(DW), .SEL(MUL_A0)) u_a0_ud (.v(u_d), .y(a0_ud));
  db4_csd_mul #(.DW(DW), .SEL(MUL_A0)) u_a0_l  (.v(l),   .y(a0_l));

  assign u  = g_s + c1_h;
  assign l  = h_s - c1_g;
  // stage 0 pairs the previous upper branch with the current lower branch
  assign xl = (a0_ud + l) >>> 2;
  assign xu = (u_d - a0_l) >>> 2;

  assign in_ready = (phase == PH_EVEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= PH_EVEN;
      out_valid <= 1'b0;
      x_out     <= '0;
      u_d       <= '0;
      xu_r      <= '0;
    end else if (phase == PH_ODD) begin
      x_out     <= OW'(xu_r >>> SCALE_SH);
      out_valid <= 1'b1;
      phase     <= PH_EVEN;
    end else if (in_valid) begin
      u_d       <= u;
      xu_r      <= xu;
      x_out     <= OW'(xl >>> SCALE_SH);
      out_valid <= 1'b1;
      phase     <= PH_ODD;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
